// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//
// Read-side consumer for the async FIFO, living entirely in the FIFO read
// clock domain. It watches the FIFO fill level and, once a full burst of
// BURST_LEN words is available, drains exactly that many words onto a
// valid/ready stream, flagging the final beat of the burst with m_last.
//
// The FIFO RAM returns data one cycle after the read strobe is sampled, so a
// 2-entry output buffer absorbs that latency. Reads are only issued when the
// buffer plus the word in flight cannot overflow, which lets the block
// sustain one beat per cycle under backpressure without dropping data.
//
// Optional feature (macro RD_TIMEOUT_FLUSH_EN):
//   When defined, an idle timer counts cycles with a partial fill
//   (0 < data_avail < BURST_LEN). After TIMEOUT such cycles the residual
//   words are flushed as a short burst. When undefined, only full bursts are
//   issued and residual words remain in the FIFO.
//
// Ports:
//   rd_clk        FIFO read clock (single clock)
//   rst           synchronous, active-high reset
//   fifo_rd_en    read strobe to FIFO, one word popped per high cycle
//   fifo_rd_data  FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty    FIFO empty flag
//   data_avail    number of words available in the FIFO
//   m_valid       output beat valid
//   m_data        output beat data
//   m_last        final beat of the current burst (qualified by m_valid)
//   m_ready       downstream accept
//   busy          high while the controller is not idle
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
    parameter int DATA_W    = 16,
    parameter int FIFO_D    = 32,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                      rd_clk,
    input  logic                      rst,
    output logic                      fifo_rd_en,
    input  logic [DATA_W-1:0]         fifo_rd_data,
    input  logic                      fifo_empty,
    input  logic [$clog2(FIFO_D):0]   data_avail,
    output logic                      m_valid,
    output logic [DATA_W-1:0]         m_data,
    output logic                      m_last,
    input  logic                      m_ready,
    output logic                      busy
);

    localparam int AVAIL_W = $clog2(FIFO_D) + 1;

    localparam logic [AVAIL_W-1:0] BURST_LEN_C = AVAIL_W'(BURST_LEN);
    localparam logic [AVAIL_W-1:0] ONE_C       = AVAIL_W'(1);
    localparam logic [AVAIL_W-1:0] ZERO_C      = AVAIL_W'(0);

    // Elaboration-time sanity check of the configuration.
    if (BURST_LEN < 1 || BURST_LEN > FIFO_D || TIMEOUT < 1 || DATA_W < 1) begin : g_bad_params
        $error("fifo_burst_reader: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state_r;
    logic [AVAIL_W-1:0]   remaining_r;
    logic [AVAIL_W-1:0]   beats_left_r;
    logic                 inflight_r;
    logic [1:0]           occ_r;
    logic [DATA_W-1:0]    head_r;
    logic [DATA_W-1:0]    tail_r;
    logic                 m_valid_r;
    logic                 m_last_r;
    logic                 busy_r;

    logic                 pop_s;
    logic                 push_s;
    logic                 room_s;
    logic                 rd_en_s;
    logic [1:0]           occ_nxt_s;
    logic                 start_full_s;
    logic                 flush_s;
    logic                 load_s;
    logic [AVAIL_W-1:0]   load_len_s;
    logic [AVAIL_W-1:0]   beats_left_nxt_s;

`ifdef RD_TIMEOUT_FLUSH_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TIMEOUT_C = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE_C = TMR_W'(1);

    logic [TMR_W-1:0] timer_r;

    // Flush a short burst once the partial fill has waited long enough.
    always_comb begin
        flush_s = (timer_r == TIMEOUT_C) && (data_avail != ZERO_C);
    end

    // Idle timer: counts partial-fill cycles, saturating at TIMEOUT.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            timer_r <= '0;
        end else if ((state_r != ST_IDLE) || load_s) begin
            timer_r <= '0;
        end else if (data_avail == ZERO_C) begin
            timer_r <= '0;
        end else if ((data_avail < BURST_LEN_C) && (timer_r < TIMEOUT_C)) begin
            timer_r <= timer_r + TMR_ONE_C;
        end else begin
            timer_r <= timer_r;
        end
    end
`else
    // Without the timer no short burst is ever launched.
    always_comb begin
        flush_s = 1'b0;
    end
`endif

    // Read strobe and buffer bookkeeping. The strobe has to react to
    // fifo_empty and m_ready in the same cycle, so it is a decode of
    // registered state plus those two inputs rather than a register.
    // A read is allowed while buffer + in-flight word leaves room, or when a
    // beat leaves the buffer in this very cycle to make room.
    always_comb begin
        pop_s   = m_valid_r && m_ready;
        push_s  = inflight_r;
        room_s  = (({1'b0, occ_r} + {2'b00, inflight_r}) < 3'd2) || pop_s;
        rd_en_s = (state_r == ST_BURST) && (remaining_r != ZERO_C) && !fifo_empty && room_s;
        case ({push_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + 2'd1;
            2'b01:   occ_nxt_s = occ_r - 2'd1;
            default: occ_nxt_s = occ_r;
        endcase
    end

    // Burst launch decision and beat countdown for the current burst.
    always_comb begin
        start_full_s = (data_avail >= BURST_LEN_C);
        load_s       = (state_r == ST_IDLE) && (start_full_s || flush_s);
        if (start_full_s) begin
            load_len_s = BURST_LEN_C;
        end else begin
            load_len_s = data_avail;
        end
        if (load_s) begin
            beats_left_nxt_s = load_len_s;
        end else if (pop_s) begin
            beats_left_nxt_s = beats_left_r - ONE_C;
        end else begin
            beats_left_nxt_s = beats_left_r;
        end
    end

    // Two-entry output buffer: head_r is presented, tail_r queues behind it.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            inflight_r <= 1'b0;
            occ_r      <= 2'd0;
            head_r     <= '0;
            tail_r     <= '0;
            m_valid_r  <= 1'b0;
        end else begin
            inflight_r <= rd_en_s;
            occ_r      <= occ_nxt_s;
            m_valid_r  <= (occ_nxt_s != 2'd0);
            case ({push_s, pop_s})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        head_r <= fifo_rd_data;
                    end else begin
                        tail_r <= fifo_rd_data;
                    end
                end
                2'b01: begin
                    head_r <= tail_r;
                end
                2'b11: begin
                    // With one entry the arriving word becomes the new head;
                    // with two it slots in behind the promoted tail.
                    if (occ_r == 2'd1) begin
                        head_r <= fifo_rd_data;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= fifo_rd_data;
                    end
                end
                default: begin
                    head_r <= head_r;
                    tail_r <= tail_r;
                end
            endcase
        end
    end

    // Burst controller: IDLE -> BURST (issue reads) -> DRAIN (deliver rest).
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            remaining_r  <= '0;
            beats_left_r <= '0;
            m_last_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            beats_left_r <= beats_left_nxt_s;
            // Only the buffer head can be the final beat, so require it to exist.
            m_last_r     <= (beats_left_nxt_s == ONE_C) && (occ_nxt_s != 2'd0);
            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        state_r     <= ST_BURST;
                        remaining_r <= load_len_s;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                    end
                end
                ST_BURST: begin
                    busy_r <= 1'b1;
                    if (rd_en_s) begin
                        remaining_r <= remaining_r - ONE_C;
                        if (remaining_r == ONE_C) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_BURST;
                        end
                    end else begin
                        state_r <= ST_BURST;
                    end
                end
                ST_DRAIN: begin
                    if (pop_s && (beats_left_r == ONE_C)) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_DRAIN;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    remaining_r <= '0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en = rd_en_s;
    assign m_valid    = m_valid_r;
    assign m_data     = head_r;
    assign m_last     = m_last_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// Testbench for fifo_burst_reader. A queue-based FIFO model feeds the DUT with
// one cycle of read latency; a monitor records every accepted beat. Each test
// compares the recorded stream against the order words were written, with
// m_last expected on every BURST_LEN-th beat of a burst.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

    localparam int DATA_W    = 16;
    localparam int FIFO_D    = 32;
    localparam int BURST_LEN = 8;
    localparam int TIMEOUT   = 64;
    localparam int AVAIL_W   = $clog2(FIFO_D) + 1;

    logic                rd_clk = 1'b0;
    logic                rst = 1'b1;
    logic                fifo_rd_en;
    logic [DATA_W-1:0]   fifo_rd_data = '0;
    logic                fifo_empty = 1'b1;
    logic [AVAIL_W-1:0]  data_avail = '0;
    logic                m_valid;
    logic [DATA_W-1:0]   m_data;
    logic                m_last;
    logic                m_ready = 1'b0;
    logic                busy;

    int checks = 0;
    int errors = 0;

    fifo_burst_reader #(
        .DATA_W(DATA_W), .FIFO_D(FIFO_D), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .rd_clk(rd_clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty), .data_avail(data_avail), .m_valid(m_valid),
        .m_data(m_data), .m_last(m_last), .m_ready(m_ready), .busy(busy)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO model: words popped on a sampled read strobe appear next cycle.
    logic [DATA_W-1:0] fq[$];
    logic              force_empty = 1'b0;
    int                underflow_cnt = 0;

    always @(posedge rd_clk) begin
        if (rst) begin
            fq.delete();
            fifo_rd_data  <= '0;
            data_avail    <= '0;
            fifo_empty    <= 1'b1;
            underflow_cnt <= 0;
        end else begin
            if (fifo_rd_en) begin
                if (fq.size() == 0) underflow_cnt <= underflow_cnt + 1;
                else fifo_rd_data <= fq.pop_front();
            end
            data_avail <= AVAIL_W'(fq.size());
            fifo_empty <= (fq.size() == 0) || force_empty;
        end
    end

    // Monitor: record accepted beats, read strobes, stall stability, busy rise.
    logic [DATA_W-1:0] obs_data[$];
    logic              obs_last[$];
    int                obs_cyc[$];
    int                cyc = 0;
    int                rd_cnt = 0;
    int                stall_err = 0;
    int                busy_cyc = -1;
    logic              busy_prev = 1'b0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic              prev_last = 1'b0;

    always @(posedge rd_clk) cyc <= cyc + 1;

    always @(negedge rd_clk) begin
        if (rst) begin
            obs_data.delete();
            obs_last.delete();
            obs_cyc.delete();
            rd_cnt     <= 0;
            stall_err  <= 0;
            busy_cyc   <= -1;
            busy_prev  <= 1'b0;
            prev_stall <= 1'b0;
        end else begin
            if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
            if (m_valid && m_ready) begin
                obs_data.push_back(m_data);
                obs_last.push_back(m_last);
                obs_cyc.push_back(cyc);
            end
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
                stall_err <= stall_err + 1;
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
            prev_last  <= m_last;
            if (busy && !busy_prev) busy_cyc <= cyc;
            busy_prev <= busy;
        end
    end

    logic [DATA_W-1:0] exp_q[$];

    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_ready = 1'b0;
        force_empty = 1'b0;
        exp_q.delete();
        step();
        rst = 1'b0;
    endtask

    task automatic push_words(input int n, input bit counting, input int base);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < n; i++) begin
            if (counting) w = DATA_W'(base + i);
            else w = DATA_W'($urandom);
            fq.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        int k = 0;
        while (obs_data.size() < n && k < budget) begin
            step();
            k++;
        end
        ok = (obs_data.size() >= n);
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (m_valid !== 1'b0)    begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
        if (m_data !== '0)       begin errors++; $display("FAIL reset_m_data got %h exp 0", m_data); end
        if (m_last !== 1'b0)     begin errors++; $display("FAIL reset_m_last got %b exp 0", m_last); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", fifo_rd_en); end
    endtask

    task automatic test_single_burst();
        bit ok;
        do_reset();
        m_ready = 1'b1;
        push_words(BURST_LEN, 1'b1, 1);
        wait_beats(BURST_LEN, 60, ok);
        repeat (4) step();
        checks++;
        if (!ok || obs_data.size() != BURST_LEN) begin
            errors++; $display("FAIL single_count got %0d exp %0d", obs_data.size(), BURST_LEN);
        end
        for (int i = 0; i < BURST_LEN && i < obs_data.size(); i++) begin
            checks += 3;
            if (obs_data[i] !== exp_q[i]) begin errors++; $display("FAIL single_data[%0d] got %h exp %h", i, obs_data[i], exp_q[i]); end
            if (obs_last[i] !== (i == BURST_LEN - 1)) begin errors++; $display("FAIL single_last[%0d] got %b exp %b", i, obs_last[i], (i == BURST_LEN - 1)); end
            if (obs_cyc[i] !== obs_cyc[0] + i) begin errors++; $display("FAIL single_cyc[%0d] got %0d exp %0d", i, obs_cyc[i], obs_cyc[0] + i); end
        end
        checks += 3;
        if (rd_cnt !== BURST_LEN) begin errors++; $display("FAIL single_rd_cnt got %0d exp %0d", rd_cnt, BURST_LEN); end
        if (obs_cyc.size() > 0 && obs_cyc[0] - busy_cyc !== 2) begin
            errors++; $display("FAIL single_latency got %0d exp 2", obs_cyc[0] - busy_cyc);
        end
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_random_backpressure();
        int k = 0;
        int n = 3 * BURST_LEN;
        do_reset();
        push_words(n, 1'b0, 0);
        while (obs_data.size() < n && k < 800) begin
            m_ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        m_ready = 1'b1;
        repeat (10) step();
        checks += 4;
        if (obs_data.size() != n) begin errors++; $display("FAIL bp_count got %0d exp %0d", obs_data.size(), n); end
        if (stall_err !== 0) begin errors++; $display("FAIL bp_stall_stable got %0d exp 0", stall_err); end
        if (underflow_cnt !== 0) begin errors++; $display("FAIL bp_underflow got %0d exp 0", underflow_cnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end got %b exp 0", busy); end
        for (int i = 0; i < n && i < obs_data.size(); i++) begin
            checks += 2;
            if (obs_data[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", i, obs_data[i], exp_q[i]); end
            if (obs_last[i] !== (((i + 1) % BURST_LEN) == 0)) begin
                errors++; $display("FAIL bp_last[%0d] got %b exp %b", i, obs_last[i], (((i + 1) % BURST_LEN) == 0));
            end
        end
    endtask

    task automatic test_backpressure_start();
        bit ok;
        do_reset();
        push_words(BURST_LEN, 1'b0, 0);
        repeat (20) step();
        checks += 4;
        if (rd_cnt !== 2) begin errors++; $display("FAIL stall_rd_cnt got %0d exp 2", rd_cnt); end
        if (m_valid !== 1'b1) begin errors++; $display("FAIL stall_m_valid got %b exp 1", m_valid); end
        if (m_data !== exp_q[0]) begin errors++; $display("FAIL stall_m_data got %h exp %h", m_data, exp_q[0]); end
        if (m_last !== 1'b0) begin errors++; $display("FAIL stall_m_last got %b exp 0", m_last); end
        m_ready = 1'b1;
        wait_beats(BURST_LEN, 40, ok);
        repeat (4) step();
        checks += 2;
        if (!ok || obs_data.size() != BURST_LEN) begin errors++; $display("FAIL resume_count got %0d exp %0d", obs_data.size(), BURST_LEN); end
        if (rd_cnt !== BURST_LEN) begin errors++; $display("FAIL resume_rd_cnt got %0d exp %0d", rd_cnt, BURST_LEN); end
        for (int i = 0; i < BURST_LEN && i < obs_data.size(); i++) begin
            checks += 3;
            if (obs_data[i] !== exp_q[i]) begin errors++; $display("FAIL resume_data[%0d] got %h exp %h", i, obs_data[i], exp_q[i]); end
            if (obs_last[i] !== (i == BURST_LEN - 1)) begin errors++; $display("FAIL resume_last[%0d] got %b exp %b", i, obs_last[i], (i == BURST_LEN - 1)); end
            if (obs_cyc[i] !== obs_cyc[0] + i) begin errors++; $display("FAIL resume_rate[%0d] got %0d exp %0d", i, obs_cyc[i], obs_cyc[0] + i); end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        do_reset();
        m_ready = 1'b1;
        push_words(BURST_LEN, 1'b1, 16'h0100);
        wait_beats(3, 40, ok);
        checks++;
        if (!ok || obs_data.size() != 3 || obs_data[2] !== exp_q[2]) begin
            errors++; $display("FAIL midrst_pre got %0d beats exp 3", obs_data.size());
        end
        rst = 1'b1;
        m_ready = 1'b0;
        step();
        rst = 1'b0;
        exp_q.delete();
        checks += 5;
        if (m_valid !== 1'b0)    begin errors++; $display("FAIL midrst_m_valid got %b exp 0", m_valid); end
        if (m_data !== '0)       begin errors++; $display("FAIL midrst_m_data got %h exp 0", m_data); end
        if (m_last !== 1'b0)     begin errors++; $display("FAIL midrst_m_last got %b exp 0", m_last); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL midrst_rd_en got %b exp 0", fifo_rd_en); end
        m_ready = 1'b1;
        repeat (30) step();
        checks += 2;
        if (obs_data.size() != 0) begin errors++; $display("FAIL midrst_quiet got %0d beats exp 0", obs_data.size()); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_quiet_busy got %b exp 0", busy); end
        push_words(BURST_LEN, 1'b1, 16'h0200);
        wait_beats(BURST_LEN, 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midrst_next_count got %0d exp %0d", obs_data.size(), BURST_LEN); end
        for (int i = 0; i < BURST_LEN && i < obs_data.size(); i++) begin
            checks++;
            if (obs_data[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_next_data[%0d] got %h exp %h", i, obs_data[i], exp_q[i]); end
        end
    endtask

    task automatic test_empty_toggle();
        int k = 0;
        do_reset();
        m_ready = 1'b1;
        push_words(BURST_LEN, 1'b0, 0);
        while (obs_data.size() < BURST_LEN && k < 300) begin
            force_empty = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        force_empty = 1'b0;
        repeat (10) step();
        checks += 3;
        if (obs_data.size() != BURST_LEN) begin errors++; $display("FAIL empty_count got %0d exp %0d", obs_data.size(), BURST_LEN); end
        if (rd_cnt !== BURST_LEN) begin errors++; $display("FAIL empty_rd_cnt got %0d exp %0d", rd_cnt, BURST_LEN); end
        if (underflow_cnt !== 0) begin errors++; $display("FAIL empty_underflow got %0d exp 0", underflow_cnt); end
        for (int i = 0; i < BURST_LEN && i < obs_data.size(); i++) begin
            checks += 2;
            if (obs_data[i] !== exp_q[i]) begin errors++; $display("FAIL empty_data[%0d] got %h exp %h", i, obs_data[i], exp_q[i]); end
            if (obs_last[i] !== (i == BURST_LEN - 1)) begin errors++; $display("FAIL empty_last[%0d] got %b exp %b", i, obs_last[i], (i == BURST_LEN - 1)); end
        end
    endtask

    task automatic test_residual();
        int k = 0;
        int settle;
        bit ok;
        do_reset();
        m_ready = 1'b1;
        push_words(5, 1'b1, 16'h0A01);
        while (data_avail != AVAIL_W'(5) && k < 10) begin
            step();
            k++;
        end
        settle = cyc;
`ifdef RD_TIMEOUT_FLUSH_EN
        wait_beats(5, 200, ok);
        repeat (4) step();
        checks += 3;
        if (!ok || obs_data.size() != 5) begin errors++; $display("FAIL flush_count got %0d exp 5", obs_data.size()); end
        // Timer sees the fill one edge after it settles, counts TIMEOUT cycles,
        // then launches on the following edge.
        if (busy_cyc - settle !== TIMEOUT + 1) begin
            errors++; $display("FAIL flush_delay got %0d exp %0d", busy_cyc - settle, TIMEOUT + 1);
        end
        if (rd_cnt !== 5) begin errors++; $display("FAIL flush_rd_cnt got %0d exp 5", rd_cnt); end
        for (int i = 0; i < 5 && i < obs_data.size(); i++) begin
            checks += 2;
            if (obs_data[i] !== exp_q[i]) begin errors++; $display("FAIL flush_data[%0d] got %h exp %h", i, obs_data[i], exp_q[i]); end
            if (obs_last[i] !== (i == 4)) begin errors++; $display("FAIL flush_last[%0d] got %b exp %b", i, obs_last[i], (i == 4)); end
        end
`else
        ok = 1'b1;
        repeat (1000) step();
        checks += 4;
        if (!ok || rd_cnt !== 0) begin errors++; $display("FAIL residual_rd_cnt got %0d exp 0", rd_cnt); end
        if (obs_data.size() != 0) begin errors++; $display("FAIL residual_beats got %0d exp 0", obs_data.size()); end
        if (busy !== 1'b0) begin errors++; $display("FAIL residual_busy got %b exp 0", busy); end
        if (data_avail !== AVAIL_W'(5) || settle < 0) begin errors++; $display("FAIL residual_avail got %0d exp 5", data_avail); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_random_backpressure();
        test_backpressure_start();
        test_reset_mid_burst();
        test_empty_toggle();
        test_residual();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
